// File: rtl/fact_accel.sv
// fact_accel: memory-mapped iterative factorial accelerator on the data bus.
// Ports: clk, rst (async, high), we/a/wd write port, rd combinational read, done.
//
// Register map (word offset a):
//   0 N      r/w  bits [3:0] = n, upper bits read 0
//   1 GO     w: bit0=1 starts a run; r: {31'b0, busy}
//   2 STATUS r    {30'b0, err, done}
//   3 RESULT r    last completed product
//
// Optional build macro FACT_ERR_CHK_EN: a GO with N > N_MAX does not run.
// It flags err=1, done=1 and clears RESULT. Without it err is constant 0.

module fact_accel #(
    parameter int N_MAX = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [1:0]  a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [3:0]  n_reg, n_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [31:0] prod, prod_nx;
    logic [31:0] result, result_nx;
    logic        done_q, done_nx;
    logic        err, err_nx;

    logic        n_wr;
    logic        go_wr;
    logic        range_err;
    logic        unused_bits;

    assign n_wr  = we && (a == 2'd0);
    assign go_wr = we && (a == 2'd1) && wd[0];

`ifdef FACT_ERR_CHK_EN
    assign range_err   = (32'(n_reg) > 32'(N_MAX));
    assign unused_bits = ^wd[31:4];
`else
    assign range_err   = 1'b0;
    assign unused_bits = ^{wd[31:4], 32'(N_MAX)};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            n_reg  <= 4'd0;
            cnt    <= 4'd0;
            prod   <= 32'd1;
            result <= 32'd0;
            done_q <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nx;
            n_reg  <= n_nx;
            cnt    <= cnt_nx;
            prod   <= prod_nx;
            result <= result_nx;
            done_q <= done_nx;
            err    <= err_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        n_nx      = n_reg;
        cnt_nx    = cnt;
        prod_nx   = prod;
        result_nx = result;
        done_nx   = done_q;
        err_nx    = err;

        case (state)
            BUSY: begin
                // Bus writes are dropped while a run is in flight.
                if (cnt > 4'd1) begin
                    prod_nx = prod * {28'd0, cnt};
                    cnt_nx  = cnt - 4'd1;
                end else begin
                    result_nx = prod;
                    done_nx   = 1'b1;
                    state_nx  = DONE;
                end
            end
            default: begin
                // IDLE and DONE accept N writes and new GO commands alike.
                if (n_wr) begin
                    n_nx = wd[3:0];
                end
                if (go_wr) begin
                    if (range_err) begin
                        err_nx    = 1'b1;
                        done_nx   = 1'b1;
                        result_nx = 32'd0;
                    end else begin
                        cnt_nx   = n_reg;
                        prod_nx  = 32'd1;
                        done_nx  = 1'b0;
                        err_nx   = 1'b0;
                        state_nx = BUSY;
                    end
                end
            end
        endcase
    end

    always_comb begin
        rd = 32'd0;
        case (a)
            2'd0: rd = {28'd0, n_reg};
            2'd1: rd = {31'd0, state == BUSY};
            2'd2: rd = {30'd0, err, done_q};
            2'd3: rd = result;
            default: rd = 32'd0;
        endcase
    end

    assign done = done_q;

endmodule

// File: tb/tb_fact_accel.sv
// tb_fact_accel: self-checking bench for fact_accel.
// Table vectors, hand corner sequences and random n against a factorial model.

module tb_fact_accel;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we  = 1'b0;
    logic [1:0]  a   = 2'd0;
    logic [31:0] wd  = 32'd0;
    logic [31:0] rd;
    logic        done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fact_accel #(.N_MAX(12)) dut (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .a    (a),
        .wd   (wd),
        .rd   (rd),
        .done (done)
    );

    typedef struct {
        int          n;
        logic [31:0] res;
        int          lat;
        logic        err;
    } vec_t;

    vec_t vt[6];

    function automatic logic [31:0] fact_ref(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 2; i <= n; i++) p = (p * longint'(i)) & 64'hFFFF_FFFF;
        return p[31:0];
    endfunction

    function automatic bit err_ref(input int n);
`ifdef FACT_ERR_CHK_EN
        return n > 12;
`else
        return (n < 0);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic rd_reg(input logic [1:0] off, output logic [31:0] v);
        a = off;
        #1;
        v = rd;
    endtask

    // Called at a negedge; the write lands on the next posedge.
    task automatic wr(input logic [1:0] off, input logic [31:0] val);
        we = 1'b1;
        a  = off;
        wd = val;
        @(negedge clk);
        we = 1'b0;
        wd = 32'd0;
    endtask

    // Counts posedges after the GO edge until done is seen (bounded).
    task automatic wait_done(input int start, output int lat, output int busy_n);
        logic [31:0] v;
        lat    = start;
        busy_n = 0;
        while (!done && lat < 40) begin
            rd_reg(2'd1, v);
            if (v == 32'd1) busy_n++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run(input string tag, input int n, input logic [31:0] exp_res,
                       input int exp_lat, input logic exp_err);
        int          lat, bn;
        logic [31:0] v;
        wr(2'd0, 32'(n));
        wr(2'd1, 32'd1);
        wait_done(0, lat, bn);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " busy_cycles"}, 32'(bn), 32'(exp_lat));
        chk({tag, " done_pin"}, {31'd0, done}, 32'd1);
        rd_reg(2'd2, v);
        chk({tag, " status"}, v, {30'd0, exp_err, 1'b1});
        rd_reg(2'd3, v);
        chk({tag, " result"}, v, exp_res);
        rd_reg(2'd1, v);
        chk({tag, " busy_after"}, v, 32'd0);
        rd_reg(2'd0, v);
        chk({tag, " n_readback"}, v, 32'(n));
    endtask

    initial begin
        int          n, lat, bn;
        logic [31:0] v;

        vt[0] = '{n: 5,  res: 32'h0000_0078, lat: 5,  err: 1'b0};
        vt[1] = '{n: 0,  res: 32'h0000_0001, lat: 1,  err: 1'b0};
        vt[2] = '{n: 1,  res: 32'h0000_0001, lat: 1,  err: 1'b0};
        vt[3] = '{n: 12, res: 32'h1C8C_FC00, lat: 12, err: 1'b0};
        vt[4] = '{n: 2,  res: 32'h0000_0002, lat: 2,  err: 1'b0};
`ifdef FACT_ERR_CHK_EN
        vt[5] = '{n: 13, res: 32'h0000_0000, lat: 0,  err: 1'b1};
`else
        vt[5] = '{n: 13, res: 32'h7328_CC00, lat: 13, err: 1'b0};
`endif

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            rd_reg(2'(i), v);
            chk($sformatf("reset rd[%0d]", i), v, 32'd0);
        end
        chk("reset done_pin", {31'd0, done}, 32'd0);

        for (int i = 0; i < 6; i++)
            run($sformatf("vec n=%0d", vt[i].n), vt[i].n, vt[i].res,
                vt[i].lat, vt[i].err);

        // GO with bit0=0 must not start anything.
        run("pre_nogo n=5", 5, 32'd120, 5, 1'b0);
        wr(2'd1, 32'h0000_0002);
        rd_reg(2'd1, v);
        chk("nogo busy", v, 32'd0);
        rd_reg(2'd2, v);
        chk("nogo status", v, 32'd1);
        rd_reg(2'd3, v);
        chk("nogo result", v, 32'd120);

        // Writes to read-only offsets are dropped.
        wr(2'd2, 32'hFFFF_FFFF);
        wr(2'd3, 32'h1234_5678);
        rd_reg(2'd2, v);
        chk("ro status", v, 32'd1);
        rd_reg(2'd3, v);
        chk("ro result", v, 32'd120);

        // Writes during BUSY are ignored; the run finishes unchanged.
        wr(2'd0, 32'd12);
        wr(2'd1, 32'd1);
        wr(2'd0, 32'd3);
        wr(2'd1, 32'd1);
        wait_done(2, lat, bn);
        chk("busywr latency", 32'(lat), 32'd12);
        rd_reg(2'd3, v);
        chk("busywr result", v, 32'h1C8C_FC00);
        rd_reg(2'd0, v);
        chk("busywr n", v, 32'd12);

        // Reset mid-run aborts and clears everything immediately.
        wr(2'd0, 32'd10);
        wr(2'd1, 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_reg(2'(i), v);
            chk($sformatf("midrst rd[%0d]", i), v, 32'd0);
        end
        chk("midrst done_pin", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run("after_rst n=4", 4, 32'd24, 4, 1'b0);

        // Random n against the arithmetic reference.
        for (int k = 0; k < 12; k++) begin
            n = int'($urandom_range(0, 15));
            if (err_ref(n))
                run($sformatf("rand n=%0d", n), n, 32'd0, 0, 1'b1);
            else
                run($sformatf("rand n=%0d", n), n, fact_ref(n),
                    (n < 1) ? 1 : n, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
